// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/status bundle between the multicycle controller and the LEGv8 datapath.
// Latency: n/a (wiring only).
// Backpressure: mem_ready is the only stall input; the controller holds its memory request until it is seen.
// Ports: Op/zero/mem_ready flow datapath->controller; enables, mux selects, illegal, state_o and
//        instr_count flow controller->datapath. master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [10:0]      Op;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCSrc;
  logic             IRWrite;
  logic             Reg2Loc;
  logic             ALUSrc;
  logic [1:0]       ALUOp;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic             illegal;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  Op, zero, mem_ready,
    output PCWrite, PCSrc, IRWrite, Reg2Loc, ALUSrc, ALUOp, MemRead, MemWrite,
           MemtoReg, RegWrite, illegal, state_o, instr_count
  );

  modport slave (
    output Op, zero, mem_ready,
    input  PCWrite, PCSrc, IRWrite, Reg2Loc, ALUSrc, ALUOp, MemRead, MemWrite,
           MemtoReg, RegWrite, illegal, state_o, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencing a shared ALU/unified memory for LDUR, STUR, CBZ and R-format.
// Latency: R 4, LDUR 5, STUR 4, CBZ 3, illegal 2 cycles; +1 per mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR.
// Backpressure: FETCH, MEM_RD and MEM_WR hold their request until mem_ready=1; other states ignore it.
// Ports: clk (rising edge), reset (async, active low), bus (master modport: Op/zero/mem_ready in,
//        datapath enables/selects, illegal pulse, state_o and retired-instruction count out).
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC_R = 4'd3,
    WB_R   = 4'd4,
    ADDR   = 4'd5,
    MEM_RD = 4'd6,
    WB_LD  = 4'd7,
    MEM_WR = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t           state_q, state_d;
  logic             retire;
  logic [CNT_W-1:0] instr_count_q;

  // Outputs that depend only on the state are registered from state_d so they line up with state_q.
  logic       mem_read_q, mem_write_q, alu_src_q, mem_to_reg_q, reg_write_q, reg2loc_q;
  logic [1:0] alu_op_q;

  logic is_ldur, is_stur, is_cbz, is_rfmt, is_legal;

  assign is_ldur  = (bus.Op == 11'b11111000010);
  assign is_stur  = (bus.Op == 11'b11111000000);
  assign is_cbz   = (bus.Op[10:3] == 8'b10110100);
  assign is_rfmt  = (bus.Op == 11'b10001011000) || (bus.Op == 11'b11001011000) ||
                    (bus.Op == 11'b10001010000) || (bus.Op == 11'b10101010000);
  assign is_legal = is_ldur || is_stur || is_cbz || is_rfmt;

  always_comb begin
    state_d = IDLE;
    retire  = 1'b0;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (is_rfmt)                 state_d = EXEC_R;
        else if (is_ldur || is_stur) state_d = ADDR;
        else if (is_cbz)             state_d = BRANCH;
        else                         state_d = FETCH;
      end
      EXEC_R: state_d = WB_R;
      WB_R: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      // Op is held by the IR, so the load/store choice made in DECODE is still valid here.
      ADDR:   state_d = is_stur ? MEM_WR : MEM_RD;
      MEM_RD: state_d = bus.mem_ready ? WB_LD : MEM_RD;
      WB_LD: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      MEM_WR: begin
        state_d = bus.mem_ready ? FETCH : MEM_WR;
        retire  = bus.mem_ready;
      end
      BRANCH: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      instr_count_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      alu_src_q     <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      reg_write_q   <= 1'b0;
      reg2loc_q     <= 1'b0;
      alu_op_q      <= 2'b00;
    end else begin
      state_q <= state_d;
      if (retire) instr_count_q <= instr_count_q + CNT_W'(1);
      mem_read_q   <= (state_d == FETCH) || (state_d == MEM_RD);
      mem_write_q  <= (state_d == MEM_WR);
      alu_src_q    <= (state_d == ADDR) || (state_d == MEM_RD) || (state_d == MEM_WR);
      mem_to_reg_q <= (state_d == WB_LD);
      reg_write_q  <= (state_d == WB_R) || (state_d == WB_LD);
      reg2loc_q    <= (state_d == MEM_WR) || (state_d == BRANCH);
      if ((state_d == EXEC_R) || (state_d == WB_R)) alu_op_q <= 2'b10;
      else if (state_d == BRANCH)                   alu_op_q <= 2'b01;
      else                                          alu_op_q <= 2'b00;
    end
  end

  // Mealy terms: fetch completion, taken branch, and the Op-dependent DECODE outputs
  // (the IR is only loaded on the edge entering DECODE, so these cannot be pre-registered).
  assign bus.IRWrite     = (state_q == FETCH) && bus.mem_ready;
  assign bus.PCWrite     = ((state_q == FETCH) && bus.mem_ready) || ((state_q == BRANCH) && bus.zero);
  assign bus.PCSrc       = (state_q == BRANCH) && bus.zero;
  assign bus.Reg2Loc     = reg2loc_q || ((state_q == DECODE) && (is_stur || is_cbz));
  assign bus.illegal     = (state_q == DECODE) && !is_legal;
  assign bus.ALUSrc      = alu_src_q;
  assign bus.ALUOp       = alu_op_q;
  assign bus.MemRead     = mem_read_q;
  assign bus.MemWrite    = mem_write_q;
  assign bus.MemtoReg    = mem_to_reg_q;
  assign bus.RegWrite    = reg_write_q;
  assign bus.state_o     = state_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized instruction streams for multicycle_ctrl against a path-list model.
// Latency: n/a (testbench).
// Backpressure: random mem_ready stalls in FETCH/MEM_RD/MEM_WR, random mem_ready elsewhere.
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;  // small so the retired counter wraps during the random run

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_BAD  = 11'b00000001111;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus();
  multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model: current state, instruction class, remaining state path of the instruction, retired count.
  int exp_state;
  int exp_cls;
  int exp_cnt;
  int path[$];
  int obs_state;

  // 0 R-format, 1 LDUR, 2 STUR, 3 CBZ, 4 illegal
  function automatic int classify(logic [10:0] op);
    if (op == OP_LDUR) return 1;
    if (op == OP_STUR) return 2;
    if (op[10:3] == 8'b10110100) return 3;
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return 0;
    return 4;
  endfunction

  function automatic int base_latency(int cls);
    case (cls)
      0: return 4;
      1: return 5;
      2: return 4;
      3: return 3;
      default: return 2;
    endcase
  endfunction

  // {PCWrite,PCSrc,IRWrite,Reg2Loc,ALUSrc,ALUOp[1:0],MemRead,MemWrite,MemtoReg,RegWrite,illegal}
  function automatic logic [11:0] exp_ctrl(int st, logic [10:0] op, logic z, logic mr);
    logic pcw, pcs, irw, r2l, als, mrd, mwr, m2r, rw, ill;
    logic [1:0] aop;
    int cls;
    pcw = 0; pcs = 0; irw = 0; r2l = 0; als = 0; mrd = 0; mwr = 0; m2r = 0; rw = 0; ill = 0;
    aop = 2'b00;
    cls = classify(op);
    case (st)
      1: begin mrd = 1; irw = mr; pcw = mr; end
      2: begin r2l = (cls == 2) || (cls == 3); ill = (cls == 4); end
      3: aop = 2'b10;
      4: begin rw = 1; aop = 2'b10; end
      5: als = 1;
      6: begin mrd = 1; als = 1; end
      7: begin rw = 1; m2r = 1; end
      8: begin mwr = 1; r2l = 1; als = 1; end
      9: begin r2l = 1; aop = 2'b01; pcw = z; pcs = z; end
      default: ;
    endcase
    return {pcw, pcs, irw, r2l, als, aop, mrd, mwr, m2r, rw, ill};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] dut_ctrl();
    return {bus.PCWrite, bus.PCSrc, bus.IRWrite, bus.Reg2Loc, bus.ALUSrc, bus.ALUOp,
            bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegWrite, bus.illegal};
  endfunction

  task automatic model_reset();
    exp_state = 0;
    exp_cnt   = 0;
    exp_cls   = 4;
    path.delete();
  endtask

  task automatic model_step();
    int ns;
    case (exp_state)
      0: ns = 1;
      1: ns = bus.mem_ready ? 2 : 1;
      2: begin
        exp_cls = classify(bus.Op);
        case (exp_cls)
          0: path = '{3, 4, 1};
          1: path = '{5, 6, 7, 1};
          2: path = '{5, 8, 1};
          3: path = '{9, 1};
          default: path = '{1};
        endcase
        ns = path.pop_front();
      end
      6, 8: ns = bus.mem_ready ? path.pop_front() : exp_state;
      default: ns = path.pop_front();
    endcase
    // An instruction retires when it returns to FETCH from past DECODE.
    if (ns == 1 && exp_state >= 3) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    exp_state = ns;
  endtask

  // One clock: check at the falling edge, advance the model on the rising edge, return 1 time unit later.
  task automatic tick();
    @(negedge clk);
    check("ctrl", 64'(dut_ctrl()), 64'(exp_ctrl(exp_state, bus.Op, bus.zero, bus.mem_ready)));
    check("state", 64'(bus.state_o), 64'(exp_state));
    check("count", 64'(bus.instr_count), 64'(exp_cnt));
    check("rd_and_wr", 64'(bus.MemRead & bus.MemWrite), 64'd0);
    check("regw_and_wr", 64'(bus.RegWrite & bus.MemWrite), 64'd0);
    obs_state = int'(bus.state_o);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  // Runs one instruction starting in FETCH and checks its total cycle count.
  task automatic run_instr(input logic [10:0] op, input logic z, input int fstall, input int mstall);
    int cyc;
    int fs;
    int ms;
    int cls;
    bit left;
    bit done;
    cyc = 0; fs = fstall; ms = mstall; left = 0; done = 0;
    cls = classify(op);
    bus.Op = op;
    while (!done && cyc < 40) begin
      if (exp_state == 1) begin
        bus.mem_ready = (fs > 0) ? 1'b0 : 1'b1;
        if (fs > 0) fs--;
      end else if (exp_state == 6 || exp_state == 8) begin
        bus.mem_ready = (ms > 0) ? 1'b0 : 1'b1;
        if (ms > 0) ms--;
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      bus.zero = (exp_state == 9) ? z : 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (obs_state != 1) left = 1;
      done = left && (bus.state_o == 4'd1);
    end
    check("latency", 64'(cyc),
          64'(base_latency(cls) + fstall + ((cls == 1 || cls == 2) ? mstall : 0)));
  endtask

  initial begin
    logic [10:0] rop;
    int sel;
    bus.Op = 11'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();

    // Reset held for three cycles, then IDLE and the first FETCH.
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Directed instruction mix.
    run_instr(OP_ADD, 1'b0, 0, 0);
    run_instr(OP_LDUR, 1'b0, 0, 2);
    run_instr(OP_STUR, 1'b0, 0, 0);
    run_instr(OP_CBZ, 1'b1, 0, 0);
    run_instr(OP_CBZ, 1'b0, 0, 0);
    run_instr(OP_BAD, 1'b0, 0, 0);
    run_instr(OP_SUB, 1'b0, 2, 0);
    run_instr(OP_AND, 1'b0, 0, 0);
    run_instr(OP_ORR, 1'b1, 1, 0);
    run_instr(OP_STUR, 1'b0, 1, 3);

    // Asynchronous reset while a store is stalled in MEM_WR.
    bus.Op = OP_STUR;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) tick();
    bus.mem_ready = 1'b0;
    tick();
    check("pre_arst_memwrite", 64'(bus.MemWrite), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", 64'(dut_ctrl()), 64'd0);
    check("arst_state", 64'(bus.state_o), 64'd0);
    check("arst_count", 64'(bus.instr_count), 64'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    tick();

    // Randomized instruction stream with random stalls; the counter wraps along the way.
    repeat (200) begin
      sel = $urandom_range(0, 8);
      case (sel)
        0: rop = OP_LDUR;
        1: rop = OP_STUR;
        2: begin rop = OP_CBZ; rop[2:0] = 3'($urandom_range(0, 7)); end
        3: rop = OP_ADD;
        4: rop = OP_SUB;
        5: rop = OP_AND;
        6: rop = OP_ORR;
        default: rop = 11'($urandom_range(0, 2047));
      endcase
      run_instr(rop, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM for a multicycle LEGv8 core. It replaces the single-cycle main decoder by sequencing a shared datapath (one ALU, one unified memory) across FETCH/DECODE/EXECUTE/MEM/WB steps for LDUR, STUR, CBZ and R-format (ADD/SUB/AND/ORR). The controller sits between the instruction register's opcode field and the datapath's enables and muxes. It stalls on a memory-ready handshake.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
Op  input  11  instr[31:21] from IR; stable from DECODE until the next FETCH
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current MemRead/MemWrite this cycle
PCWrite  output  1  load PC
PCSrc  output  1  0 = PC+4, 1 = branch target
IRWrite  output  1  load IR from memory read data
Reg2Loc  output  1  read-register-2 select (1 = Rt)
ALUSrc  output  1  0 = register, 1 = sign-extended immediate
ALUOp  output  2  00 add, 01 pass-B/zero test, 10 funct-decode
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemtoReg  output  1  write-back select (1 = memory data)
RegWrite  output  1  register file write enable
illegal  output  1  single-cycle pulse on an undecodable Op
state_o  output  4  current state encoding
instr_count  output  CNT_W  retired-instruction counter

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, WB_R=4, ADDR=5, MEM_RD=6, WB_LD=7, MEM_WR=8, BRANCH=9. Codes 10–15 are unreachable; if entered, next state is IDLE.
- Reset (reset=0, asynchronous): state=IDLE, instr_count=0, all outputs 0. The first FETCH occurs on the first rising edge after reset deasserts. Reset mid-instruction aborts immediately; no partial write persists beyond the current cycle.
- Opcode classes:
  - LDUR = 11111000010
  - STUR = 11111000000
  - CBZ = 10110100xxx
  - R-format = 10001011000, 11001011000, 10001010000, 10101010000
  - Anything else is illegal.
- All outputs not listed for a state are 0.
- IDLE: all outputs 0 -> FETCH.
- FETCH: MemRead=1, ALUOp=00. IRWrite=PCWrite=mem_ready (Mealy), PCSrc=0. Stay until mem_ready=1, then -> DECODE.
- DECODE: Reg2Loc=1 if Op is STUR or CBZ, else 0. Transitions:
  - R -> EXEC_R
  - LDUR/STUR -> ADDR
  - CBZ -> BRANCH
  - illegal -> FETCH, with illegal=1 for this cycle only; instr_count is not incremented.
- EXEC_R: ALUSrc=0, ALUOp=10 -> WB_R.
- WB_R: RegWrite=1, MemtoReg=0, ALUOp=10 -> FETCH; instr_count+1.
- ADDR: ALUSrc=1, ALUOp=00. Next state is MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: MemRead=1, ALUSrc=1, ALUOp=00. Stay while mem_ready=0; -> WB_LD.
- WB_LD: RegWrite=1, MemtoReg=1 -> FETCH; instr_count+1.
- MEM_WR: MemWrite=1, Reg2Loc=1, ALUSrc=1, ALUOp=00. Stay while mem_ready=0; -> FETCH and instr_count+1 on the mem_ready cycle.
- BRANCH: Reg2Loc=1, ALUSrc=0, ALUOp=01. PCWrite=zero and PCSrc=zero (Mealy) -> FETCH; instr_count+1 regardless of taken/not-taken.
- Latency with mem_ready held at 1:
  - R-format: 4 cycles
  - LDUR: 5 cycles
  - STUR: 4 cycles
  - CBZ: 3 cycles
  - illegal: 2 cycles
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- MemRead and MemWrite are never both 1.
- RegWrite and MemWrite are never 1 in the same cycle.
- instr_count wraps modulo 2^CNT_W.
- mem_ready is ignored in states without a memory request.

Test Plan:
- Reset: hold reset=0 for 3 cycles with mem_ready=1 -> all outputs 0, state_o=0. After release: IDLE then FETCH (state_o=1, MemRead=1, IRWrite=1, PCWrite=1).
- R-format sequence: Op=10001011000, mem_ready=1 -> state_o 1,2,3,4,1. RegWrite=1 only in WB_R. ALUOp=10 in EXEC_R/WB_R. instr_count 0->1.
- LDUR with memory stall: Op=11111000010, mem_ready=0 for 2 cycles in MEM_RD -> MEM_RD held 3 cycles with MemRead=1. WB_LD has MemtoReg=1, RegWrite=1. Total 7 cycles.
- STUR and CBZ taken/not-taken:
  - STUR (11111000000) -> MemWrite=1, Reg2Loc=1 in MEM_WR; RegWrite stays 0.
  - CBZ (10110100101) with zero=1 -> PCWrite=1, PCSrc=1 in BRANCH.
  - CBZ with zero=0 -> PCWrite=0.
- Illegal opcode: Op=00000001111 -> illegal=1 for exactly one cycle in DECODE, then FETCH. No RegWrite/MemWrite; instr_count unchanged.
- Async reset mid-operation: drop reset in MEM_WR while mem_ready=0 -> MemWrite and all outputs go 0 immediately (before the next edge), state_o=0, instr_count=0.
